mpeg_decode_scheduler: RTL and testbench
========================================

// Module: mpeg_decode_scheduler
// PURPOSE
//  Sits between an mpeg_demuxer and its elementary-stream decoder.
//  Queues the decoding timestamps (DTS) the demuxer reports and releases one decode-start pulse per entry once the local 45 kHz clock reaches that DTS.
//  Drops entries that are hopelessly late and tracks program end so the playback path drains cleanly.
//  One instance per stream (audio or video).
// PARAMETERS
//  DEPTH       4     DTS queue entries (power of two, 2..16)
//  LEAD_TICKS  0     release this many 90 kHz ticks before DTS (0..2^16-1)
//  LATE_TICKS  9000  drop entry if overdue by more than this (90 kHz ticks; 100 ms)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high
//  dclk              in   32  local time, increments at 45 kHz
//  scr_start_time    in   33  signed; demuxer start time, 90 kHz units
//  scr_start_valid   in   1   scr_start_time is valid (level)
//  dts_in            in   33  signed; demuxer decoding_timestamp
//  dts_in_valid      in   1   1-cycle pulse, push dts_in
//  program_end       in   1   1-cycle pulse, demuxer saw end code 0xB9
//  playback_enable   in   1   0 = pause; queue holds, nothing released
//  decoder_ready     in   1   decoder can accept a start this cycle
//  decode_start      out  1   1-cycle pulse, start decoding one unit
//  decode_dts        out  33  DTS of released entry, valid with decode_start
//  late_drop         out  1   1-cycle pulse, head entry discarded as late
//  overflow          out  1   sticky; a push was lost on a full queue
//  queue_count       out  $clog2(DEPTH)+1  current occupancy
//  running           out  1   state == RUN
//  program_done      out  1   sticky; end seen and queue drained
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, state WAIT_START; reset mid-operation discards queue contents.
//  Time base:
//   - now = {dclk,1'b0} - scr_start_time, 33-bit wrapping subtraction.
//   - diff = now - head_dts + LEAD_TICKS, 33-bit signed.
//   - due  = diff >= 0.
//   - late = diff > LATE_TICKS + LEAD_TICKS.
//   - All compares are signed 33-bit, so wrap of dclk is handled.
//  Queue (FIFO):
//   - Push on dts_in_valid in every state except DONE.
//   - Push when full and no pop in the same cycle: entry dropped, overflow <= 1.
//   - Push and pop in the same cycle are both honoured, including at full and at empty+push (pop uses the old head only when nonempty).
//   - queue_count is registered and updates the cycle after the event.
//  FSM:
//   - WAIT_START -> RUN when scr_start_valid && playback_enable. Queue fills meanwhile.
//   - RUN, evaluated each cycle with playback_enable=1 and queue nonempty, in priority order:
//      1. late: pop, late_drop pulse (decoder_ready ignored).
//      2. due && decoder_ready: pop, decode_start pulse, decode_dts <= head.
//      3. otherwise hold.
//   - RUN: program_end -> DRAIN.
//   - DRAIN: same release rules as RUN; when queue empty and no push that cycle -> DONE, program_done <= 1.
//   - DONE: pushes ignored, no pulses. Left only via reset, or scr_start_valid falling (new sequence) -> WAIT_START with queue cleared and program_done <= 0.
//   - program_end in WAIT_START: -> DRAIN directly; entries are still released against the time base once scr_start_valid is 1, otherwise flushed silently.
//   - playback_enable=0 in RUN/DRAIN: state holds, no pops. Late check is resumed when re-enabled (a long pause may drop several entries, one per cycle).
//  Latency: due condition to decode_start is 1 cycle (registered). At most one pop per cycle.
//  decode_dts holds its value between starts.
// STRUCTURE
//  Package mpeg_pkg:
//   - typedef logic signed [32:0] mpeg_ts_t.
//   - enum sched_state_t {WAIT_START, RUN, DRAIN, DONE}.
//   - localparam TICKS_90K_PER_45K = 2.
//  Sub-module mpeg_ts_fifo:
//   - DEPTH x mpeg_ts_t, registered count, show-ahead head, push/pop/full/empty.
//   - Overflow decision stays in the scheduler.
// TESTING
//  - Basic: scr_start=0, push dts 9000 and 18000, enable, ready=1 -> decode_start when dclk reaches 4500 (dts 9000), then at 9000 (dts 18000).
//  - Lead: LEAD_TICKS=900, dts 9000 -> start at dclk 4050.
//  - Late drop: dclk=10000, push dts 1000 (diff 19000 > 9000) -> late_drop pulse, no decode_start, count returns to 0.
//  - Backpressure/overflow: ready=0, push 5 entries into DEPTH=4 -> overflow=1, count=4, first four DTS released in order once ready=1.
//  - Wrap: scr_start=0, dclk=32'hFFFF_FFF0, dts=33'h0_0000_0010 -> start when dclk reaches 8 after wrap.
//  - End/drain/reset: push 2, program_end -> both released, program_done=1; pushes in DONE ignored; reset mid-RUN -> count 0, outputs 0.

Source files
------------

// File: rtl/mpeg_pkg.sv
// Shared timestamp type, scheduler states and 45k->90k tick conversion.
// Pure declarations: no latency and no flow control.
package mpeg_pkg;
    typedef logic signed [32:0] mpeg_ts_t;

    typedef enum logic [1:0] {
        WAIT_START,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int TICKS_90K_PER_45K = 2;

    function automatic mpeg_ts_t dclk_to_90k(input logic [31:0] dclk);
        return mpeg_ts_t'({1'b0, dclk}) * mpeg_ts_t'(TICKS_90K_PER_45K);
    endfunction
endpackage

// File: rtl/mpeg_ts_fifo.sv
// Show-ahead DTS FIFO with registered count; count/head update one cycle after push/pop.
// A push is accepted when not full or when a pop is honoured in the same cycle.
module mpeg_ts_fifo
    import mpeg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic signed [32:0]         i_push_dat,
    input  logic                       i_pop,
    output logic signed [32:0]         o_head_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mpeg_ts_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mpeg_decode_scheduler.sv
// Releases one decode-start per queued DTS when local time reaches it; drops late entries.
// Start/drop pulses are registered one cycle after the decision; decoder_ready=0 holds the head.
module mpeg_decode_scheduler
    import mpeg_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LEAD_TICKS = 0,
    parameter int LATE_TICKS = 9000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [31:0]                i_dclk,
    input  logic signed [32:0]         i_scr_start_time,
    input  logic                       i_scr_start_valid,
    input  logic signed [32:0]         i_dts_in,
    input  logic                       i_dts_in_valid,
    input  logic                       i_program_end,
    input  logic                       i_playback_enable,
    input  logic                       i_decoder_ready,
    output logic                       o_decode_start,
    output logic signed [32:0]         o_decode_dts,
    output logic                       o_late_drop,
    output logic                       o_overflow,
    output logic [$clog2(DEPTH):0]     o_queue_count,
    output logic                       o_running,
    output logic                       o_program_done
);
    localparam mpeg_ts_t LEAD_TS  = mpeg_ts_t'(LEAD_TICKS);
    localparam mpeg_ts_t LATE_LIM = mpeg_ts_t'(LATE_TICKS + LEAD_TICKS);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic        r_scr_vld_d;
    logic        r_decode_start;
    mpeg_ts_t    r_decode_dts;
    logic        r_late_drop;
    logic        r_overflow;
    logic        r_program_done;

    mpeg_ts_t    w_now;
    mpeg_ts_t    w_diff;
    mpeg_ts_t    w_head;
    logic        w_due;
    logic        w_late;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_start;
    logic        w_drop;
    logic        w_clear;
    logic        w_set_done;
    logic        w_release_ok;

    // Signed 33-bit wrapping arithmetic keeps ordering correct across dclk wrap.
    assign w_now  = dclk_to_90k(i_dclk) - i_scr_start_time;
    assign w_diff = w_now - w_head + LEAD_TS;
    assign w_due  = !w_diff[32];
    assign w_late = (w_diff > LATE_LIM);

    assign w_push       = i_dts_in_valid && (r_state != DONE);
    assign w_release_ok = ((r_state == RUN) || (r_state == DRAIN)) &&
                          i_playback_enable && !w_empty;

    mpeg_ts_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_clear),
        .i_push     (w_push),
        .i_push_dat (i_dts_in),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (o_queue_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_clear     = 1'b0;
        w_set_done  = 1'b0;

        // Draining without a time base means there is nothing to schedule against: flush silently.
        if (w_release_ok) begin
            if ((r_state == DRAIN) && !i_scr_start_valid) begin
                w_pop = 1'b1;
            end else if (w_late) begin
                w_pop  = 1'b1;
                w_drop = 1'b1;
            end else if (w_due && i_decoder_ready) begin
                w_pop   = 1'b1;
                w_start = 1'b1;
            end
        end

        case (r_state)
            WAIT_START: begin
                if (i_program_end) begin
                    w_state_nxt = DRAIN;
                end else if (i_scr_start_valid && i_playback_enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_program_end) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty && !i_dts_in_valid) begin
                    w_state_nxt = DONE;
                    w_set_done  = 1'b1;
                end
            end
            DONE: begin
                if (r_scr_vld_d && !i_scr_start_valid) begin
                    w_state_nxt = WAIT_START;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_START;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= WAIT_START;
            r_scr_vld_d    <= 1'b0;
            r_decode_start <= 1'b0;
            r_decode_dts   <= '0;
            r_late_drop    <= 1'b0;
            r_overflow     <= 1'b0;
            r_program_done <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_scr_vld_d    <= i_scr_start_valid;
            r_decode_start <= w_start;
            r_late_drop    <= w_drop;
            if (w_start) begin
                r_decode_dts <= w_head;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_set_done) begin
                r_program_done <= 1'b1;
            end else if (w_clear) begin
                r_program_done <= 1'b0;
            end
        end
    end

    assign o_decode_start = r_decode_start;
    assign o_decode_dts   = r_decode_dts;
    assign o_late_drop    = r_late_drop;
    assign o_overflow     = r_overflow;
    assign o_running      = (r_state == RUN);
    assign o_program_done = r_program_done;
endmodule

// File: tb/tb_mpeg_decode_scheduler.sv
// Directed-vector bench for mpeg_decode_scheduler; a second instance runs with a 900-tick lead.
module tb_mpeg_decode_scheduler;
    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        dclk;
    logic signed [32:0] scr_start_time;
    logic               scr_start_valid;
    logic signed [32:0] dts_in;
    logic               dts_in_valid;
    logic               program_end;
    logic               playback_enable;
    logic               decoder_ready;

    logic               decode_start, l_decode_start;
    logic signed [32:0] decode_dts, l_decode_dts;
    logic               late_drop, l_late_drop;
    logic               overflow, l_overflow;
    logic [2:0]         queue_count, l_queue_count;
    logic               running, l_running;
    logic               program_done, l_program_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mpeg_decode_scheduler #(.DEPTH(4), .LEAD_TICKS(0), .LATE_TICKS(9000)) dut (
        .i_clk(clk), .i_reset(reset), .i_dclk(dclk),
        .i_scr_start_time(scr_start_time), .i_scr_start_valid(scr_start_valid),
        .i_dts_in(dts_in), .i_dts_in_valid(dts_in_valid),
        .i_program_end(program_end), .i_playback_enable(playback_enable),
        .i_decoder_ready(decoder_ready),
        .o_decode_start(decode_start), .o_decode_dts(decode_dts),
        .o_late_drop(late_drop), .o_overflow(overflow),
        .o_queue_count(queue_count), .o_running(running),
        .o_program_done(program_done)
    );

    mpeg_decode_scheduler #(.DEPTH(4), .LEAD_TICKS(900), .LATE_TICKS(9000)) dut_lead (
        .i_clk(clk), .i_reset(reset), .i_dclk(dclk),
        .i_scr_start_time(scr_start_time), .i_scr_start_valid(scr_start_valid),
        .i_dts_in(dts_in), .i_dts_in_valid(dts_in_valid),
        .i_program_end(program_end), .i_playback_enable(playback_enable),
        .i_decoder_ready(decoder_ready),
        .o_decode_start(l_decode_start), .o_decode_dts(l_decode_dts),
        .o_late_drop(l_late_drop), .o_overflow(l_overflow),
        .o_queue_count(l_queue_count), .o_running(l_running),
        .o_program_done(l_program_done)
    );

    task automatic chk_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        dclk            = '0;
        scr_start_time  = '0;
        scr_start_valid = 1'b0;
        dts_in          = '0;
        dts_in_valid    = 1'b0;
        program_end     = 1'b0;
        playback_enable = 1'b0;
        decoder_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic signed [32:0] dts);
        dts_in       = dts;
        dts_in_valid = 1'b1;
        tick();
        dts_in_valid = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] t, input logic rdy);
        scr_start_valid = 1'b1;
        playback_enable = 1'b1;
        decoder_ready   = rdy;
        dclk            = t;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        tick();
        chk_vec("rst_start", decode_start, 0);
        chk_vec("rst_dts", decode_dts, 0);
        chk_vec("rst_late", late_drop, 0);
        chk_vec("rst_ovf", overflow, 0);
        chk_vec("rst_count", queue_count, 0);
        chk_vec("rst_running", running, 0);
        chk_vec("rst_done", program_done, 0);

        // Basic: dts 9000 due at dclk 4500, dts 18000 at dclk 9000
        scr_start_valid = 1'b1;
        decoder_ready   = 1'b1;
        push(33'sd9000);
        push(33'sd18000);
        chk_vec("basic_count2", queue_count, 2);
        chk_vec("basic_wait", running, 0);
        playback_enable = 1'b1;
        tick();
        chk_vec("basic_running", running, 1);
        dclk = 32'd4499; tick();
        chk_vec("basic_early", decode_start, 0);
        dclk = 32'd4500; tick();
        chk_vec("basic_start1", decode_start, 1);
        chk_vec("basic_dts1", decode_dts, 9000);
        chk_vec("basic_count1", queue_count, 1);
        tick();
        chk_vec("basic_pulse", decode_start, 0);
        chk_vec("basic_hold", decode_dts, 9000);
        dclk = 32'd8999; tick();
        chk_vec("basic_early2", decode_start, 0);
        dclk = 32'd9000; tick();
        chk_vec("basic_start2", decode_start, 1);
        chk_vec("basic_dts2", decode_dts, 18000);
        chk_vec("basic_count0", queue_count, 0);

        // Lead of 900 ticks releases dts 9000 at dclk 4050
        do_reset();
        start_run(32'd0, 1'b1);
        push(33'sd9000);
        dclk = 32'd4049; tick();
        chk_vec("lead_early", l_decode_start, 0);
        dclk = 32'd4050; tick();
        chk_vec("lead_start", l_decode_start, 1);
        chk_vec("lead_dts", l_decode_dts, 9000);
        chk_vec("lead_nolead", decode_start, 0);
        dclk = 32'd4500; tick();
        chk_vec("lead_ref_start", decode_start, 1);

        // Late drop: diff 19000 > 9000; diff exactly 9000 still released
        do_reset();
        start_run(32'd10000, 1'b1);
        push(33'sd1000);
        chk_vec("late_count1", queue_count, 1);
        chk_vec("late_not_yet", late_drop, 0);
        tick();
        chk_vec("late_drop", late_drop, 1);
        chk_vec("late_nostart", decode_start, 0);
        chk_vec("late_count0", queue_count, 0);
        push(33'sd11000);
        tick();
        chk_vec("late_edge_start", decode_start, 1);
        chk_vec("late_edge_nodrop", late_drop, 0);
        chk_vec("late_edge_dts", decode_dts, 11000);

        // Backpressure and overflow
        do_reset();
        start_run(32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push(33'(100 * (i + 1)));
        end
        chk_vec("ovf_flag", overflow, 1);
        chk_vec("ovf_count", queue_count, 4);
        dclk = 32'd1000;
        decoder_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_vec("ovf_rel_start", decode_start, 1);
            chk_vec("ovf_rel_dts", decode_dts, 64'(100 * (i + 1)));
        end
        tick();
        chk_vec("ovf_drained", queue_count, 0);
        chk_vec("ovf_nostart", decode_start, 0);
        chk_vec("ovf_sticky", overflow, 1);

        // Reset in the middle of RUN discards the queue
        decoder_ready = 1'b0;
        push(33'sd700);
        push(33'sd800);
        chk_vec("mid_count2", queue_count, 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_vec("mid_count0", queue_count, 0);
        chk_vec("mid_running", running, 0);
        chk_vec("mid_ovf", overflow, 0);
        chk_vec("mid_start", decode_start, 0);

        // dclk wrap: dts 0x10 released at dclk 8 after wrap
        do_reset();
        start_run(32'hFFFF_FFF0, 1'b1);
        push(33'sh0_0000_0010);
        tick();
        chk_vec("wrap_pre", decode_start, 0);
        chk_vec("wrap_nolate", late_drop, 0);
        dclk = 32'd7; tick();
        chk_vec("wrap_early", decode_start, 0);
        dclk = 32'd8; tick();
        chk_vec("wrap_start", decode_start, 1);
        chk_vec("wrap_dts", decode_dts, 64'h10);

        // End of program, drain, DONE, restart sequence
        do_reset();
        start_run(32'd0, 1'b1);
        push(33'sd200);
        push(33'sd400);
        program_end = 1'b1; tick(); program_end = 1'b0;
        chk_vec("end_drain", running, 0);
        chk_vec("end_count", queue_count, 2);
        dclk = 32'd100; tick();
        chk_vec("end_start1", decode_start, 1);
        chk_vec("end_dts1", decode_dts, 200);
        dclk = 32'd200; tick();
        chk_vec("end_start2", decode_start, 1);
        chk_vec("end_dts2", decode_dts, 400);
        chk_vec("end_notdone", program_done, 0);
        tick();
        chk_vec("end_done", program_done, 1);
        push(33'sd600);
        chk_vec("done_ignore", queue_count, 0);
        tick();
        chk_vec("done_nostart", decode_start, 0);
        chk_vec("done_sticky", program_done, 1);
        scr_start_valid = 1'b0; tick();
        chk_vec("restart_done", program_done, 0);
        chk_vec("restart_count", queue_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
